median_window_feeder: RTL and testbench

- Upstream driver for the 3x3 median filter. Accepts a raster-order 8-bit pixel stream and keeps two line buffers.
- Forms each full 3x3 neighbourhood, presents it on nine window outputs and holds the filter enable high until the filter reports done.
- Captures the median and emits it on a valid/ready result stream.
- Sits between the pixel source and the median filter.

---
 rtl/median_window_feeder_pkg.sv | 13 +
 rtl/median_window_feeder_line_buf.sv | 21 ++
 rtl/median_window_feeder.sv | 173 +++++++++++++++++
 tb/tb_median_window_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/median_window_feeder_pkg.sv
// Shared types and constants for the median filter window feeder.
package median_pkg;
    localparam int PIX_W = 8;
    localparam int WIN_N = 9;

    typedef enum logic [2:0] {
        FILL,
        LOAD,
        RUN,
        RELEASE,
        EMIT
    } state_t;
endpackage

// File: rtl/median_window_feeder_line_buf.sv
// Single-port line memory: one row of pixels, combinational read at the write address.
module median_line_buf
    import median_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rdata_o
);
    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end

    assign rdata_o = mem[addr_i];
endmodule

// File: rtl/median_window_feeder.sv
// Raster-stream to 3x3 window feeder for the median filter, with result capture.
// Optional RUN watchdog enabled by defining MEDIAN_FEEDER_TIMEOUT_EN.
module median_window_feeder
    import median_pkg::*;
#(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int MED_MIN_LAT = 6,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pix_valid_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic             pix_ready_o,
    output logic [PIX_W-1:0] win_o_0,
    output logic [PIX_W-1:0] win_o_1,
    output logic [PIX_W-1:0] win_o_2,
    output logic [PIX_W-1:0] win_o_3,
    output logic [PIX_W-1:0] win_o_4,
    output logic [PIX_W-1:0] win_o_5,
    output logic [PIX_W-1:0] win_o_6,
    output logic [PIX_W-1:0] win_o_7,
    output logic [PIX_W-1:0] win_o_8,
    output logic             med_en_o,
    input  logic [PIX_W-1:0] med_data_i,
    input  logic             med_done_i,
    output logic             res_valid_o,
    output logic [PIX_W-1:0] res_o,
    input  logic             res_ready_i,
    output logic             res_err_o
);
    localparam int COL_W   = $clog2(IMG_W);
    localparam int ROW_W   = $clog2(IMG_H);
    localparam int CNT_TOP = (MED_MIN_LAT > TIMEOUT) ? MED_MIN_LAT : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] lat_cnt;
    logic [PIX_W-1:0] lb0_q, lb1_q;
    logic [PIX_W-1:0] win_q   [WIN_N];
    logic [PIX_W-1:0] win_out [WIN_N];
    logic             xfer, win_done, done_ok;

    assign xfer     = pix_valid_i & pix_ready_o;
    assign win_done = (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign done_ok  = med_done_i && (lat_cnt >= CNT_W'(MED_MIN_LAT - 1));

    // lb0 holds the previous row, lb1 the row before; both advance on every transfer.
    median_line_buf #(.DEPTH(IMG_W)) u_lb0 (
        .clk_i  (clk_i),
        .we_i   (xfer),
        .addr_i (col),
        .wdata_i(pix_i),
        .rdata_o(lb0_q)
    );

    median_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk_i  (clk_i),
        .we_i   (xfer),
        .addr_i (col),
        .wdata_i(lb0_q),
        .rdata_o(lb1_q)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q <= '{default: '0};
        end else if (xfer) begin
            win_q[0] <= win_q[1];
            win_q[1] <= win_q[2];
            win_q[2] <= lb1_q;
            win_q[3] <= win_q[4];
            win_q[4] <= win_q[5];
            win_q[5] <= lb0_q;
            win_q[6] <= win_q[7];
            win_q[7] <= win_q[8];
            win_q[8] <= pix_i;
        end
    end

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
    logic res_err_q;
    assign res_err_o = res_err_q;
`else
    assign res_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= FILL;
            col         <= '0;
            row         <= '0;
            lat_cnt     <= '0;
            pix_ready_o <= 1'b0;
            med_en_o    <= 1'b0;
            res_valid_o <= 1'b0;
            res_o       <= '0;
            win_out     <= '{default: '0};
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
            res_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    pix_ready_o <= 1'b1;
                    if (xfer) begin
                        if (col == COL_W'(IMG_W - 1)) begin
                            col <= '0;
                            row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (win_done) begin
                            pix_ready_o <= 1'b0;
                            state       <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    win_out  <= win_q;
                    med_en_o <= 1'b1;
                    lat_cnt  <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    // lat_cnt doubles as the watchdog; it saturates above both limits
                    if (lat_cnt != '1) lat_cnt <= lat_cnt + 1'b1;
                    if (done_ok) begin
                        res_o    <= med_data_i;
                        med_en_o <= 1'b0;
                        state    <= RELEASE;
                    end
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
                    else if (lat_cnt == CNT_W'(TIMEOUT - 1)) begin
                        res_o     <= '0;
                        res_err_q <= 1'b1;
                        med_en_o  <= 1'b0;
                        state     <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    res_valid_o <= 1'b1;
                    state       <= EMIT;
                end
                EMIT: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        pix_ready_o <= 1'b1;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
                        res_err_q   <= 1'b0;
`endif
                        state       <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign win_o_0 = win_out[0];
    assign win_o_1 = win_out[1];
    assign win_o_2 = win_out[2];
    assign win_o_3 = win_out[3];
    assign win_o_4 = win_out[4];
    assign win_o_5 = win_out[5];
    assign win_o_6 = win_out[6];
    assign win_o_7 = win_out[7];
    assign win_o_8 = win_out[8];
endmodule

// File: tb/tb_median_window_feeder.sv
// Randomised bench for median_window_feeder: emulated median filter plus a frame-level reference.
module tb_median_window_feeder;
    localparam int W      = 8;
    localparam int H      = 8;
    localparam int MINLAT = 6;
    localparam int TMO    = 64;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       pix_valid;
    logic [7:0] pix;
    logic       pix_ready_o;
    logic [7:0] win_o_0, win_o_1, win_o_2, win_o_3, win_o_4, win_o_5, win_o_6, win_o_7, win_o_8;
    logic       med_en_o;
    logic [7:0] med_data;
    logic       med_done;
    logic       res_valid_o;
    logic [7:0] res_o;
    logic       res_ready;
    logic       res_err_o;

    always #5 clk = ~clk;

    median_window_feeder #(
        .IMG_W(W), .IMG_H(H), .MED_MIN_LAT(MINLAT), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .pix_valid_i(pix_valid), .pix_i(pix), .pix_ready_o(pix_ready_o),
        .win_o_0(win_o_0), .win_o_1(win_o_1), .win_o_2(win_o_2),
        .win_o_3(win_o_3), .win_o_4(win_o_4), .win_o_5(win_o_5),
        .win_o_6(win_o_6), .win_o_7(win_o_7), .win_o_8(win_o_8),
        .med_en_o(med_en_o), .med_data_i(med_data), .med_done_i(med_done),
        .res_valid_o(res_valid_o), .res_o(res_o), .res_ready_i(res_ready),
        .res_err_o(res_err_o)
    );

    typedef struct {
        logic [7:0]  med;
        logic        err;
        logic [71:0] win;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  cur [W*H];
    int          n_pass = 0;
    int          n_checks = 0;
    int          results_seen = 0;
    int          mode = 0;          // 0 normal filter, 1 done stuck high, 2 done stuck low
    int          filt_cnt = 0;
    int          lat_w = 0;
    bit          stall_arm = 0;
    logic [71:0] win_bus;

    assign win_bus = {win_o_0, win_o_1, win_o_2, win_o_3, win_o_4, win_o_5, win_o_6, win_o_7, win_o_8};

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] med9(input logic [71:0] w);
        logic [7:0] a [9];
        logic [7:0] t;
        for (int i = 0; i < 9; i++) a[i] = w[71-8*i -: 8];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    function automatic logic [71:0] win_at(input int r, input int c);
        logic [71:0] w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w = {w[63:0], cur[(r-2+dr)*W + c-2+dc]};
        return w;
    endfunction

    // Emulated filter: fresh median only after MINLAT-1 enable cycles, done after lat_w cycles.
    always @(posedge clk) begin
        filt_cnt <= med_en_o ? filt_cnt + 1 : 0;
        if (!med_en_o) lat_w <= (mode == 1) ? 0 : int'($urandom_range(0, 12));
    end

    always_comb begin
        med_done = (mode == 2) ? 1'b0 : (filt_cnt >= lat_w);
        med_data = (filt_cnt >= MINLAT - 1) ? med9(win_bus) : 8'hEE;
    end

    task automatic load_frame(input bit ramp, input bit push);
        exp_t e;
        for (int i = 0; i < W*H; i++) cur[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
        if (push)
            for (int r = 2; r < H; r++)
                for (int c = 2; c < W; c++) begin
                    e.win = win_at(r, c);
                    e.med = med9(e.win);
                    e.err = 1'b0;
                    exp_q.push_back(e);
                end
    endtask

    task automatic send_pixels(input int n);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 20000) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pix = cur[idx];
            @(negedge clk);
            if (pix_valid && pix_ready_o) idx++;
            @(posedge clk);
            #1;
            guard++;
        end
        pix_valid = 1'b0;
        check("pixels_sent", 72'(idx), 72'(n));
    endtask

    task automatic wait_results(input int exp_count);
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain", 72'(exp_q.size()), 72'(0));
        check("result_count", 72'(results_seen), 72'(exp_count));
    endtask

    // Result consumer: mostly ready, with one long stall when armed.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_arm && res_valid_o && results_seen == 3) begin
                res_ready = 1'b0;
                repeat (20) @(posedge clk);
                stall_arm = 0;
            end else begin
                res_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: enable-pulse length, back-pressure, and result scoreboard.
    initial begin
        int   en_run = 0;
        int   lat_snap = 0;
        int   exp_run;
        bit   prev_en = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                en_run = 0;
                prev_en = 0;
            end else begin
                if (med_en_o) begin
                    if (en_run == 0) lat_snap = lat_w;
                    en_run++;
                end else if (prev_en) begin
                    exp_run = (mode == 2) ? TMO : (((lat_snap > MINLAT - 1) ? lat_snap : MINLAT - 1) + 1);
                    check("en_cycles", 72'(en_run), 72'(exp_run));
                    en_run = 0;
                end
                prev_en = med_en_o;
                if (res_valid_o) check("ready_low_while_busy", 72'(pix_ready_o), 72'(0));
                if (res_valid_o && res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 72'(1), 72'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("median", 72'(res_o), 72'(e.med));
                        check("err_flag", 72'(res_err_o), 72'(e.err));
                        check("window", win_bus, e.win);
                    end
                    results_seen++;
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst_ni = 1'b0;
        pix_valid = 1'b0;
        pix = '0;
        #12;
        check("rst_ctrl", 72'({pix_ready_o, med_en_o, res_valid_o, res_o, res_err_o}), 72'(0));
        check("rst_win", win_bus, 72'(0));
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Ramp frame, normal filter timing
        mode = 0; results_seen = 0;
        load_frame(1'b1, 1'b1);
        send_pixels(W*H);
        wait_results((W-2)*(H-2));

        // Sticky done on a random frame, with a 20-cycle consumer stall at result 3
        mode = 1; results_seen = 0; stall_arm = 1;
        load_frame(1'b0, 1'b1);
        send_pixels(W*H);
        wait_results((W-2)*(H-2));
        check("stall_taken", 72'(stall_arm), 72'(0));

        // Asynchronous reset while the filter is running
        mode = 0; results_seen = 0;
        load_frame(1'b1, 1'b0);
        send_pixels(2*W + 3);
        begin
            int g = 0;
            while (!med_en_o && g < 100) begin @(posedge clk); g++; end
        end
        check("en_before_reset", 72'(med_en_o), 72'(1));
        repeat (2) @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check("midrun_rst_en", 72'(med_en_o), 72'(0));
        check("midrun_rst_ctrl", 72'({pix_ready_o, med_en_o, res_valid_o, res_o, res_err_o}), 72'(0));
        check("midrun_rst_win", win_bus, 72'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        load_frame(1'b1, 1'b1);
        send_pixels(W*H);
        wait_results((W-2)*(H-2));

        // Two random frames back to back
        results_seen = 0;
        load_frame(1'b0, 1'b1);
        send_pixels(W*H);
        load_frame(1'b0, 1'b1);
        send_pixels(W*H);
        wait_results(2*(W-2)*(H-2));

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
        // Done never arrives: watchdog result
        mode = 2; results_seen = 0;
        load_frame(1'b1, 1'b0);
        e.win = win_at(2, 2);
        e.med = 8'h00;
        e.err = 1'b1;
        exp_q.push_back(e);
        send_pixels(2*W + 3);
        wait_results(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
